// File: rtl/i2c_reg_sequencer_pkg.sv
// Shared encodings and the step-to-command table for the I2C register sequencer.
package i2c_reg_sequencer_pkg;

    // Byte-level command encoding understood by the I2C master.
    typedef enum logic [2:0] {
        k_START_CMD   = 3'd0,
        k_WRITE_CMD   = 3'd1,
        k_READ_CMD    = 3'd2,
        k_STOP_CMD    = 3'd3,
        k_RESTART_CMD = 3'd4
    } cmd_e;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } seq_state_e;

    localparam int unsigned STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;

    localparam step_t      WRITE_STOP_STEP = 3'd4;
    localparam step_t      READ_STOP_STEP  = 3'd6;
    // READ din bit0 tells the master this is the last byte, so it NACKs it.
    localparam logic [7:0] READ_LAST_DIN   = 8'h01;

    // Command issued at a given step of a register write or read.
    function automatic cmd_e step_cmd(input logic rnw, input step_t step);
        cmd_e cmd;
        cmd = k_STOP_CMD;
        if (rnw) begin
            case (step)
                3'd0:             cmd = k_START_CMD;
                3'd1, 3'd2, 3'd4: cmd = k_WRITE_CMD;
                3'd3:             cmd = k_RESTART_CMD;
                3'd5:             cmd = k_READ_CMD;
                default:          cmd = k_STOP_CMD;
            endcase
        end else begin
            case (step)
                3'd0:             cmd = k_START_CMD;
                3'd1, 3'd2, 3'd3: cmd = k_WRITE_CMD;
                default:          cmd = k_STOP_CMD;
            endcase
        end
        return cmd;
    endfunction

    // Byte handed to the master alongside the command of a given step.
    function automatic logic [7:0] step_din(input logic       rnw,
                                            input step_t      step,
                                            input logic [6:0] dev_addr,
                                            input logic [7:0] reg_addr,
                                            input logic [7:0] wdata);
        logic [7:0] din;
        din = 8'h00;
        case (step)
            3'd1: din = {dev_addr, 1'b0};
            3'd2: din = reg_addr;
            3'd3: din = rnw ? 8'h00 : wdata;
            3'd4: din = rnw ? {dev_addr, 1'b1} : 8'h00;
            3'd5: din = rnw ? READ_LAST_DIN : 8'h00;
            default: din = 8'h00;
        endcase
        return din;
    endfunction

    // Index of the STOP step, used as the jump target after a NACK.
    function automatic step_t stop_step(input logic rnw);
        return rnw ? READ_STOP_STEP : WRITE_STOP_STEP;
    endfunction

    // Byte commands complete with a done tick; the others only need m_ready.
    function automatic logic is_byte_cmd(input cmd_e cmd);
        return (cmd == k_WRITE_CMD) || (cmd == k_READ_CMD);
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Expands one register read/write request into the I2C master's byte-level
// command stream and returns a single response with data, NACK and timeout.
module i2c_reg_sequencer
    import i2c_reg_sequencer_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic [2:0] m_cmd,
    output logic [7:0] m_din,
    output logic       m_write,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);

    seq_state_e state_q, state_d;
    step_t      step_q, step_d;

    logic       rnw_q, rnw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       timeout_q, timeout_d;
    logic       done_seen_q, done_seen_d;
    logic       ack_q, ack_d;
    cmd_e       cmd_q, cmd_d;
    logic [7:0] din_q, din_d;
    logic [15:0] wait_cnt_q;

    cmd_e       cur_cmd;
    logic [7:0] cur_din;
    logic       cur_byte;
    logic       timeout_hit;
    logic       done_now;
    logic       got_done;
    logic       ack_now;

    // Command and byte belonging to the current step.
    assign cur_cmd  = step_cmd(rnw_q, step_q);
    assign cur_din  = step_din(rnw_q, step_q, dev_q, reg_q, wdata_q);
    assign cur_byte = is_byte_cmd(cur_cmd);

    // Fires on the cycle that would bring the wait count up to the limit.
    assign timeout_hit = (({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, TIMEOUT_CYCLES});

    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = timeout_q;

    // Next-state, datapath updates and master/requester strobes.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        step_d      = step_q;
        rnw_d       = rnw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        timeout_d   = timeout_q;
        done_seen_d = done_seen_q;
        ack_d       = ack_q;
        cmd_d       = cmd_q;
        din_d       = din_q;
        req_ready   = (state_q == S_IDLE);
        rsp_valid   = 1'b0;
        m_write     = 1'b0;
        m_cmd       = cmd_q;
        m_din       = din_q;
        done_now    = 1'b0;
        got_done    = 1'b0;
        ack_now     = ack_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rnw_d       = req_rnw;
                    dev_d       = req_dev_addr;
                    reg_d       = req_reg_addr;
                    wdata_d     = req_wdata;
                    rdata_d     = 8'h00;
                    nack_d      = 1'b0;
                    timeout_d   = 1'b0;
                    ack_d       = 1'b0;
                    done_seen_d = 1'b0;
                    step_d      = '0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (m_ready) begin
                    m_write     = 1'b1;
                    m_cmd       = cur_cmd;
                    m_din       = cur_din;
                    cmd_d       = cur_cmd;
                    din_d       = cur_din;
                    done_seen_d = 1'b0;
                    state_d     = S_GUARD;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end

            // The master drops m_ready only after seeing the strobe, so its
            // stale idle level is skipped for one cycle.
            S_GUARD: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                done_now = m_done_tick && cur_byte;
                got_done = done_seen_q || done_now;
                if (done_now) begin
                    done_seen_d = 1'b1;
                    ack_now     = m_ack;
                    if (cur_cmd == k_WRITE_CMD) begin
                        ack_d = m_ack;
                    end else begin
                        rdata_d = m_dout;
                    end
                end
                if (m_ready && (!cur_byte || got_done)) begin
                    if (cur_cmd == k_STOP_CMD) begin
                        state_d = S_RESP;
                    end else if ((cur_cmd == k_WRITE_CMD) && ack_now) begin
                        nack_d  = 1'b1;
                        step_d  = stop_step(rnw_q);
                        state_d = S_ISSUE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_ISSUE;
                    end
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end

            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before the edge, regardless of block ordering.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request shadow, response and held master-command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            rnw_q       <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            nack_q      <= 1'b0;
            timeout_q   <= 1'b0;
            done_seen_q <= 1'b0;
            ack_q       <= 1'b0;
            cmd_q       <= k_START_CMD;
            din_q       <= 8'h00;
        end else begin
            step_q      <= step_d;
            rnw_q       <= rnw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            timeout_q   <= timeout_d;
            done_seen_q <= done_seen_d;
            ack_q       <= ack_d;
            cmd_q       <= cmd_d;
            din_q       <= din_d;
        end
    end

    // Per-command wait counter: clears on any state change, counts while
    // waiting on the master, and saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 16'h0000;
        end else if (state_d != state_q) begin
            wait_cnt_q <= 16'h0000;
        end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                     (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

endmodule
